// File: rtl/tile_load_ctrl_pkg.sv
// tile_load_ctrl_pkg
//   Shared types and constants for the tile load controller.
//   - state_e     : single-bank fill/full state
//   - TILE_CNT_W  : width of the delivered-tile counter
//   - calc_idxw() : fill index width for an N-entry tile (minimum 1)
package tile_load_ctrl_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam int TILE_CNT_W = 16;

  function automatic int calc_idxw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_bank.sv
// tile_bank
//   N x BW operand register bank with a one-hot per-entry write enable and a
//   parallel read port. Entries clear to zero on reset.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low clear
//     i_we     per-entry write enable (one-hot or zero)
//     i_data   word written to every enabled entry
//     o_tile   parallel read of all entries
module tile_bank #(
  parameter int BW = 10,
  parameter int N  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_we,
  input  logic [BW-1:0] i_data,
  output logic [BW-1:0] o_tile [N]
);

  logic [BW-1:0] r_mem [N];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < N; i++) r_mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i_we[i]) r_mem[i] <= i_data;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) o_tile[i] = r_mem[i];
  end

endmodule

// File: rtl/tile_load_ctrl.sv
// tile_load_ctrl
//   Loads a WIDTH x HEIGHT tile of BW-bit operands, one word per handshake,
//   in row-major order, and presents the completed tile in parallel under a
//   valid/ready handshake.
//   Build option: define TILE_LOAD_CTRL_PINGPONG_EN for two banks (fill one
//   while the other is presented); otherwise one bank with a FILL/FULL FSM.
//   Ports:
//     clk, rstn               clock / asynchronous active-low reset
//     flush                   synchronous abort of fill and held tiles
//     in_data/valid/ready     operand stream
//     tile/tile_valid/ready   parallel tile output; entry i = row i/WIDTH, col i%WIDTH
//     fill_idx                next entry to be written
//     tile_cnt                tiles delivered (wraps)
module tile_load_ctrl
  import tile_load_ctrl_pkg::*;
#(
  parameter int  BW     = 10,
  parameter int  WIDTH  = 1,
  parameter int  HEIGHT = 1,
  localparam int N      = WIDTH * HEIGHT,
  localparam int IDXW   = calc_idxw(N)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [BW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BW-1:0]         tile [N],
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic [IDXW-1:0]       fill_idx,
  output logic [TILE_CNT_W-1:0] tile_cnt
);

  logic [IDXW-1:0]       r_fill_idx;
  logic [TILE_CNT_W-1:0] r_tile_cnt;
  logic                  w_in_ready;
  logic                  w_tile_valid;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_consume;
  logic [N-1:0]          w_onehot;

  // flush discards any word or consumption in its cycle
  assign w_accept  = in_valid && w_in_ready && !flush;
  assign w_last    = w_accept && (r_fill_idx == IDXW'(N - 1));
  assign w_consume = w_tile_valid && tile_ready && !flush;

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < N; i++) w_onehot[i] = (r_fill_idx == IDXW'(i));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fill_idx <= '0;
    end else if (flush || w_last) begin
      r_fill_idx <= '0;
    end else if (w_accept) begin
      r_fill_idx <= r_fill_idx + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tile_cnt <= '0;
    end else if (w_consume) begin
      r_tile_cnt <= r_tile_cnt + TILE_CNT_W'(1);
    end
  end

`ifdef TILE_LOAD_CTRL_PINGPONG_EN

  logic          r_wb;
  logic          r_rb;
  logic [1:0]    r_fc;
  logic [N-1:0]  w_we0;
  logic [N-1:0]  w_we1;
  logic [BW-1:0] w_bank0 [N];
  logic [BW-1:0] w_bank1 [N];

  assign w_in_ready   = (r_fc < 2'd2);
  assign w_tile_valid = (r_fc != 2'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wb <= 1'b0;
      r_rb <= 1'b0;
      r_fc <= '0;
    end else if (flush) begin
      r_wb <= 1'b0;
      r_rb <= 1'b0;
      r_fc <= '0;
    end else begin
      if (w_last)    r_wb <= ~r_wb;
      if (w_consume) r_rb <= ~r_rb;
      // completion and consumption together leave the full count unchanged
      case ({w_last, w_consume})
        2'b10:   r_fc <= r_fc + 2'd1;
        2'b01:   r_fc <= r_fc - 2'd1;
        default: r_fc <= r_fc;
      endcase
    end
  end

  assign w_we0 = (w_accept && !r_wb) ? w_onehot : '0;
  assign w_we1 = (w_accept &&  r_wb) ? w_onehot : '0;

  tile_bank #(.BW(BW), .N(N)) u_bank0 (
    .i_clk   (clk),
    .i_rst_n (rstn),
    .i_we    (w_we0),
    .i_data  (in_data),
    .o_tile  (w_bank0)
  );

  tile_bank #(.BW(BW), .N(N)) u_bank1 (
    .i_clk   (clk),
    .i_rst_n (rstn),
    .i_we    (w_we1),
    .i_data  (in_data),
    .o_tile  (w_bank1)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) tile[i] = r_rb ? w_bank1[i] : w_bank0[i];
  end

`else

  state_e       r_state;
  state_e       w_state_nxt;
  logic [N-1:0] w_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // transitions use raw inputs so the handshake decode stays out of this block
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_tile_valid = 1'b0;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_fill_idx == IDXW'(N - 1))) w_state_nxt = FULL;
      end
      FULL: begin
        w_tile_valid = 1'b1;
        if (tile_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
    if (flush) w_state_nxt = FILL;
  end

  assign w_we = w_accept ? w_onehot : '0;

  tile_bank #(.BW(BW), .N(N)) u_bank (
    .i_clk   (clk),
    .i_rst_n (rstn),
    .i_we    (w_we),
    .i_data  (in_data),
    .o_tile  (tile)
  );

`endif

  assign in_ready   = w_in_ready;
  assign tile_valid = w_tile_valid;
  assign fill_idx   = r_fill_idx;
  assign tile_cnt   = r_tile_cnt;

endmodule
